clockworks_divider: RTL and testbench
=====================================

Name: clockworks_divider

Overview:
- Clock and reset generator at the top of the SoC, between the board clock/reset button and the CPU core.
- Divides the board clock by 2^(SLOW+1) to produce a slow system clock, so the CPU can be single-stepped visibly on LEDs.
- Produces a system reset aligned to the slow clock, stretched over a programmable number of slow cycles.
- Provides a one-cycle clock-enable tick for logic that stays in the fast domain.

Parameters:
- SLOW, 24, divider exponent, range 0..30; slow clock period = 2^(SLOW+1) clk cycles.
- RST_HOLD, 2, number of slow-clock rising edges during which slow_reset stays asserted after reset is released, range 1..255.

Ports:
- clk  input  1  board clock; all internal flops clock on its rising edge.
- reset  input  1  reset, synchronous, active-high; already synchronised to clk (debounce is external).
- slow_clk  output  1  divided clock, 50% duty, equal to MSB of the divider counter.
- slow_reset  output  1  system reset for the slow domain, active-high, registered in the clk domain.
- slow_tick  output  1  one-clk-cycle pulse coinciding with each slow_clk high phase start.

Behaviour:
- Divider: (SLOW+1)-bit counter cnt, incremented by 1 every clk edge, wraps 2^(SLOW+1)-1 -> 0.
- slow_clk = cnt[SLOW]: low for cnt < 2^SLOW, high otherwise. SLOW=0 gives clk/2.
- slow_tick = 1 exactly when cnt == 2^SLOW, i.e. the first clk cycle of each slow_clk high phase.
- Hold counter hcnt (8 bits):
  - Loaded with RST_HOLD while reset is high.
  - After release, decrements on every slow rising edge (the clk edge making cnt == 2^SLOW) while nonzero.
- slow_reset:
  - Set to 1 while reset is high.
  - Cleared at the clk edge where slow_clk falls (cnt wraps to 0) with hcnt == 0.
  - The slow domain therefore sees slow_reset high on exactly RST_HOLD rising edges after release.
  - It changes only on slow-clock falling edges, giving a race-free setup for slow-domain flops.
- reset high at a clk edge:
  - cnt <= 0, slow_clk low next cycle; the current high phase may be truncated (accepted).
  - slow_tick low, slow_reset <= 1, hcnt <= RST_HOLD.
- Reset asserted mid-operation (slow_reset already low): same as above, and the full hold sequence restarts after release.
- Power-up initial values (FPGA init): cnt=0, hcnt=RST_HOLD, slow_reset=1. Reset is therefore generated at power-on without pressing the button.
- slow_reset never deasserts while reset is high, regardless of hcnt.
- All outputs are registered or a direct decode of registered state; no combinational path from reset to slow_clk.

Optional Feature:
- Macro CLKW_SIM_BYPASS_EN.
- When defined: the divider is bypassed for fast simulation.
  - slow_clk = clk (direct wire), slow_tick = constant 1, SLOW ignored.
  - hcnt decrements every clk edge after release.
  - slow_reset clears on the clk edge after hcnt reaches 0, so it is high for RST_HOLD clk edges after release.
- When undefined: full divider behaviour as above.

Test Plan:
- Power-up, no reset, SLOW=2, RST_HOLD=2 -> slow_reset=1 at t0; slow_clk low cycles 0-3 and high cycles 4-7 (period 8); slow_reset falls at clk edge 16.
- Reset high 3 cycles then released (edge E0 is the last edge with reset high; cnt=0 after E0), SLOW=2 -> slow_tick pulses for one cycle after edges 4, 12, 20; slow_reset low from edge 16.
- Reset reasserted while slow_clk high (cnt=6) -> next edge: cnt=0, slow_clk=0, slow_reset=1; after release, hold sequence repeats exactly (falls 16 edges later).
- RST_HOLD=1, SLOW=0 -> slow_clk toggles every clk edge; slow_reset falls at edge 2 after release.
- SLOW=3 free-running 64 cycles -> slow_clk period 16, duty 8/8, exactly 4 slow_tick pulses, each 1 cycle wide.
- CLKW_SIM_BYPASS_EN defined, RST_HOLD=2 -> slow_clk follows clk, slow_tick=1; slow_reset low from the 3rd clk edge after release.

Source files
------------

// File: rtl/clockworks_divider.sv
// Board clk -> slow_clk = clk/2^(SLOW+1), slow_reset stretched over RST_HOLD slow cycles, fast-domain slow_tick; outputs registered, no backpressure.
// Define CLKW_SIM_BYPASS_EN to bypass the divider for fast simulation (slow_clk = clk, slow_tick = 1).
module clockworks_divider #(
  parameter int SLOW     = 24,
  parameter int RST_HOLD = 2
) (
  input  logic clk,
  input  logic reset,
  output logic slow_clk,
  output logic slow_reset,
  output logic slow_tick
);

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

  // Declaration initialisers give the FPGA power-up state, so reset happens without the button.
  logic [7:0] hcnt         = HOLD_INIT;
  logic       slow_reset_q = 1'b1;

  assign slow_reset = slow_reset_q;

`ifdef CLKW_SIM_BYPASS_EN

  assign slow_clk  = clk;
  assign slow_tick = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt         <= HOLD_INIT;
      slow_reset_q <= 1'b1;
    end else begin
      if (hcnt != 8'd0)
        hcnt <= hcnt - 8'd1;
      if (hcnt == 8'd0)
        slow_reset_q <= 1'b0;
    end
  end

`else

  localparam int            CW       = SLOW + 1;
  localparam logic [SLOW:0] HALF     = CW'(1) << SLOW;
  localparam logic [SLOW:0] PRE_HALF = HALF - CW'(1);

  logic [SLOW:0] cnt = '0;
  logic          rise_next;
  logic          fall_next;

  // The edge about to make cnt == HALF is the slow rising edge; the wrap is the falling edge.
  assign rise_next = (cnt == PRE_HALF);
  assign fall_next = &cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      hcnt         <= HOLD_INIT;
      slow_reset_q <= 1'b1;
    end else begin
      cnt <= cnt + CW'(1);
      if (rise_next && (hcnt != 8'd0))
        hcnt <= hcnt - 8'd1;
      if (fall_next && (hcnt == 8'd0))
        slow_reset_q <= 1'b0;
    end
  end

  assign slow_clk  = cnt[SLOW];
  assign slow_tick = (cnt == HALF);

`endif

endmodule

// File: tb/tb_clockworks_divider.sv
// Directed bench for clockworks_divider: three instances checked every negedge against an edge-count model, plus literal pins.
module tb_clockworks_divider;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic clk_a, sr_a, tk_a;
  logic clk_b, sr_b, tk_b;
  logic clk_c, sr_c, tk_c;

  int errors = 0;
  int checks = 0;
  // Clk edges since power-up or since the last edge sampled with reset high.
  int ea = 0;
  int eb = 0;
  int ec = 0;
  int c_ticks = 0;
  int c_high  = 0;
  logic [2:0] ma, mb, mc;

  always #5 clk = ~clk;

  clockworks_divider #(.SLOW(2), .RST_HOLD(2)) dut_a (
    .clk(clk), .reset(rst_a), .slow_clk(clk_a), .slow_reset(sr_a), .slow_tick(tk_a));
  clockworks_divider #(.SLOW(0), .RST_HOLD(1)) dut_b (
    .clk(clk), .reset(rst_b), .slow_clk(clk_b), .slow_reset(sr_b), .slow_tick(tk_b));
  clockworks_divider #(.SLOW(3), .RST_HOLD(2)) dut_c (
    .clk(clk), .reset(1'b0), .slow_clk(clk_c), .slow_reset(sr_c), .slow_tick(tk_c));

  always @(posedge clk) begin
    ea <= rst_a ? 0 : ea + 1;
    eb <= rst_b ? 0 : eb + 1;
    ec <= ec + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {slow_clk, slow_tick, slow_reset} as seen mid-cycle (clk low) after e edges.
  function automatic logic [2:0] model(input int e, input int slow, input int rh);
`ifdef CLKW_SIM_BYPASS_EN
    model = {1'b0, 1'b1, (e <= rh)};
`else
    int p;
    int m;
    p = 1 << (slow + 1);
    m = e % p;
    model = {(m >= p / 2), (m == p / 2), (e < rh * p)};
`endif
  endfunction

  always @(negedge clk) begin
    ma = model(ea, 2, 2);
    mb = model(eb, 0, 1);
    mc = model(ec, 3, 2);
    chk("a_slow_clk",   clk_a, ma[2]);
    chk("a_slow_tick",  tk_a,  ma[1]);
    chk("a_slow_reset", sr_a,  ma[0]);
    chk("b_slow_clk",   clk_b, mb[2]);
    chk("b_slow_tick",  tk_b,  mb[1]);
    chk("b_slow_reset", sr_b,  mb[0]);
    chk("c_slow_clk",   clk_c, mc[2]);
    chk("c_slow_tick",  tk_c,  mc[1]);
    chk("c_slow_reset", sr_c,  mc[0]);
    if (ec >= 1 && ec <= 64) begin
      c_ticks += int'(tk_c);
      c_high  += int'(clk_c);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("a_powerup_reset", sr_a,  1);
    chk("a_powerup_clk",   clk_a, 0);
    chk("b_powerup_reset", sr_b,  1);
    chk("c_powerup_reset", sr_c,  1);
`ifdef CLKW_SIM_BYPASS_EN
    step(1);
    chk("a_byp_clk_follows", clk_a, 1);
    chk("a_byp_tick",        tk_a,  1);
    chk("a_byp_rst_e1",      sr_a,  1);
    chk("b_byp_rst_e1",      sr_b,  1);
    step(1);
    chk("a_byp_rst_e2",      sr_a,  1);
    chk("b_byp_rst_e2",      sr_b,  0);
    step(1);
    chk("a_byp_rst_e3",      sr_a,  0);
    rst_a = 1'b1;
    step(2);
    chk("a_byp_rst_held",    sr_a,  1);
    rst_a = 1'b0;
    step(2);
    chk("a_byp_rst_r2",      sr_a,  1);
    step(1);
    chk("a_byp_rst_r3",      sr_a,  0);
`else
    step(1);
    chk("b_clk_e1",   clk_b, 1);
    chk("b_rst_e1",   sr_b,  1);
    chk("a_clk_e1",   clk_a, 0);
    step(1);
    chk("b_clk_e2",   clk_b, 0);
    chk("b_rst_e2",   sr_b,  0);
    step(1);
    chk("a_clk_e3",   clk_a, 0);
    step(1);
    chk("a_clk_e4",   clk_a, 1);
    chk("a_tick_e4",  tk_a,  1);
    step(1);
    chk("a_tick_e5",  tk_a,  0);
    chk("a_clk_e5",   clk_a, 1);
    step(3);
    chk("a_clk_e8",   clk_a, 0);
    step(7);
    chk("a_rst_e15",  sr_a,  1);
    step(1);
    chk("a_rst_e16",  sr_a,  0);
    step(50);
    chk("c_tick_count", c_ticks, 4);
    chk("c_high_count", c_high,  32);

    rst_a = 1'b1;
    step(3);
    chk("a_rst_during", sr_a,  1);
    chk("a_clk_during", clk_a, 0);
    rst_a = 1'b0;
    step(4);
    chk("a_tick_r4",  tk_a, 1);
    step(1);
    chk("a_tick_r5",  tk_a, 0);
    step(7);
    chk("a_tick_r12", tk_a, 1);
    step(3);
    chk("a_rst_r15",  sr_a, 1);
    step(1);
    chk("a_rst_r16",  sr_a, 0);
    step(4);
    chk("a_tick_r20", tk_a, 1);
    step(2);
    chk("a_clk_r22",  clk_a, 1);
    rst_a = 1'b1;
    step(1);
    chk("a_reassert_clk",  clk_a, 0);
    chk("a_reassert_rst",  sr_a,  1);
    chk("a_reassert_tick", tk_a,  0);
    rst_a = 1'b0;
    step(15);
    chk("a_rehold_e15", sr_a, 1);
    step(1);
    chk("a_rehold_e16", sr_a, 0);

    rst_b = 1'b1;
    step(2);
    rst_b = 1'b0;
    step(1);
    chk("b_rst_r1", sr_b,  1);
    chk("b_clk_r1", clk_b, 1);
    step(1);
    chk("b_rst_r2", sr_b,  0);
`endif
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
